jk_q_monitor: RTL
=================

# jk_q_monitor

Downstream observer for the JK flip-flop output `q`. It samples `q` every clock and reports rising and falling edges. It also counts toggles, measures the length of each high phase, and flags a stuck output when `q` holds one level for too long. It sits beside the flip-flop in the same clock domain and feeds status to the bench or to a higher-level controller.

## Interface

Parameters:
- `CNT_W`, default 8: toggle counter width.
- `LEN_W`, default 8: run-length and high-length width.
- `STUCK_LIMIT`, default 16: number of consecutive same-level samples that declares `q` stuck. Legal range is 2 to 2^LEN_W−1.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  rising-edge clock, the same clock as the flip-flop.
- `reset`  in  1  synchronous, active-high reset.
- `q_in`  in  1  flip-flop `q`. It is synchronous to `clk`, so no synchroniser is used.
- `clear`  in  1  synchronous clear of `toggle_count`, `high_len` and `stuck`.
- `edge_rise`  out  1  one-cycle pulse when a 0→1 transition is sampled.
- `edge_fall`  out  1  one-cycle pulse when a 1→0 transition is sampled.
- `toggle_count`  out  CNT_W  total edges since reset or clear, modulo 2^CNT_W.
- `high_len`  out  LEN_W  length of the last completed high phase, in samples.
- `high_len_valid`  out  1  one-cycle pulse when `high_len` updates.
- `stuck`  out  1  high while `q` has held one level for `STUCK_LIMIT` or more samples.
- `state`  out  3  current monitor state, encoded as `jk_mon_state_t`.

## Operation

- **Reset** (highest priority): every output is 0 and `state` = UNKNOWN. The internal registers `q_d` and `run_len` are also 0.
- **States:** UNKNOWN, LOW, HIGH, STUCK_LOW, STUCK_HIGH.
- **UNKNOWN:**
  - The first sample after reset loads `q_d` ← `q_in` and sets `run_len` = 1.
  - The state moves to LOW or HIGH to match that sample.
  - No edge is reported and nothing is counted.
- **Edge:** in any state other than UNKNOWN, an edge occurs when `q_in` ≠ `q_d`. On an edge:
  - Pulse `edge_rise` or `edge_fall` to match the direction.
  - Increment `toggle_count`; it wraps to 0 after its maximum value.
  - Set `run_len` = 1.
  - Move to HIGH on a rise or LOW on a fall, leaving any STUCK state.
  - Deassert `stuck`.
- **Falling edge, additionally:** `high_len` ← the `run_len` value of the ending high phase, and `high_len_valid` pulses.
- **No edge:**
  - `run_len` increments and saturates at 2^LEN_W−1.
  - When `run_len` becomes equal to `STUCK_LIMIT`, assert `stuck` and move to STUCK_LOW or STUCK_HIGH to match the level.
  - `stuck` holds until the next edge, a `clear`, or reset.
- **`clear`:**
  - Zeroes `toggle_count`, `high_len` and `stuck`.
  - Does not change `state`, `q_d` or `run_len`. A STUCK state stays STUCK with `stuck` = 0 until the next edge.
- **`clear` and an edge in the same cycle:**
  - The edge pulses and the state update still occur.
  - `clear` wins on the counters: `toggle_count` = 0 and `high_len` = 0.
  - `high_len_valid` is suppressed.
- **Reset in the middle of a phase:** the monitor returns to UNKNOWN. The first sample after reset never produces an edge, whatever the value of `q_in`.

## Timing

- All outputs are registered.
- Latency:
  - A `q_in` change first sampled at edge N produces `edge_*`, the new `toggle_count`, `high_len`/`high_len_valid` and `state` during the cycle after edge N.
  - `stuck` asserts in the cycle after the edge at which `run_len` reaches `STUCK_LIMIT`.
- Pulses last exactly one cycle. A toggle every cycle gives `edge_rise`/`edge_fall` alternating on consecutive cycles with no gaps.
- The block has no handshake: consumers sample pulses on the cycle they are asserted.

## Structure

- Package `jk_pkg` holds:
  - `jk_mon_state_t` (3-bit enum: UNKNOWN=0, LOW, HIGH, STUCK_LOW, STUCK_HIGH).
  - Default width constants.
- One sub-module, `jk_edge_detect`:
  - Contains the `q_d` register and a valid flag, and produces combinational `rise`/`fall`.
  - Suppresses edges until the first post-reset sample has been taken.
- The top level holds the FSM, `run_len`, the counters and the output registers.

## Test plan

- Reset, then `q_in` = 0 for 3 cycles, 1 for 4 cycles, then 0 → one `edge_rise`, one `edge_fall`, `high_len` = 4 with `high_len_valid` for 1 cycle, `toggle_count` = 2.
- `q_in` held at 1 for 20 cycles → `stuck` rises in the cycle after the 16th sample and `state` = STUCK_HIGH. Then drop to 0 → `edge_fall`, `stuck` = 0, `high_len` = 20, `state` = LOW.
- `q_in` toggles every cycle (j = k = 1) for 300 edges → `toggle_count` = 44 (wrap at 256), with no missed pulses.
- `clear` asserted on the same cycle as a 1→0 edge → `edge_fall` pulses, `toggle_count` = 0, `high_len` = 0, `high_len_valid` = 0.
- Reset asserted in the middle of a high phase with `q_in` = 1, then released → all outputs 0, `state` = UNKNOWN, then HIGH after one sample, with no edge pulse and `toggle_count` = 0.
- `clear` while `state` = STUCK_LOW → `stuck` = 0 and the state stays STUCK_LOW. The next rise gives `edge_rise`, `state` = HIGH, `toggle_count` = 1.

Source files
------------

// File: rtl/jk_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : jk_pkg
//  Description : Shared types and default widths for the JK q-output monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
package jk_pkg;

    // Monitor state as seen on the state output port
    typedef enum logic [2:0] {
        UNKNOWN    = 3'd0,
        LOW        = 3'd1,
        HIGH       = 3'd2,
        STUCK_LOW  = 3'd3,
        STUCK_HIGH = 3'd4
    } jk_mon_state_t;

    // Default widths and stuck threshold
    localparam int unsigned c_def_cnt_w       = 8;
    localparam int unsigned c_def_len_w       = 8;
    localparam int unsigned c_def_stuck_limit = 16;

    // Map a settled level and its stuck condition onto a monitor state
    function automatic jk_mon_state_t jk_level_state(input logic level,
                                                     input logic is_stuck);
        jk_mon_state_t st;
        if (level) begin
            st = is_stuck ? STUCK_HIGH : HIGH;
        end else begin
            st = is_stuck ? STUCK_LOW : LOW;
        end
        return st;
    endfunction

endpackage : jk_pkg
`default_nettype wire

// File: rtl/jk_edge_detect.sv
`default_nettype none
// ============================================================================
//  Module      : jk_edge_detect
//  Description : Registers the previous q sample and flags rise/fall once a
//                first post-reset sample exists. Edge outputs are
//                combinational from the live input and the stored sample.
//  Revision    : 1.0 - initial release
// ============================================================================
module jk_edge_detect
    import jk_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic q_in,
    output logic sampled,
    output logic rise,
    output logic fall
);

    logic r_q_d;
    logic r_valid;

    // Capture the previous sample; the valid flag marks that one has been taken
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q_d   <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_q_d   <= q_in;
            r_valid <= 1'b1;
        end
    end

    // Edges are suppressed until a reference sample exists, so the first
    // sample after reset never reports an edge regardless of q_in.
    assign sampled = r_valid;
    assign rise    = r_valid &  q_in & ~r_q_d;
    assign fall    = r_valid & ~q_in &  r_q_d;

endmodule : jk_edge_detect
`default_nettype wire

// File: rtl/jk_q_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : jk_q_monitor
//  Description : Observer for a JK flip-flop q output. Reports edges, counts
//                toggles, measures completed high phases and flags a level
//                held for STUCK_LIMIT samples or more. All outputs registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module jk_q_monitor
    import jk_pkg::*;
#(
    parameter int unsigned CNT_W       = c_def_cnt_w,
    parameter int unsigned LEN_W       = c_def_len_w,
    parameter int unsigned STUCK_LIMIT = c_def_stuck_limit
)(
    input  logic               clk,
    input  logic               reset,
    input  logic               q_in,
    input  logic               clear,
    output logic               edge_rise,
    output logic               edge_fall,
    output logic [CNT_W-1:0]   toggle_count,
    output logic [LEN_W-1:0]   high_len,
    output logic               high_len_valid,
    output logic               stuck,
    output jk_mon_state_t      state
);

    localparam logic [LEN_W-1:0] c_run_max   = '1;
    localparam logic [LEN_W-1:0] c_run_one   = LEN_W'(1);
    localparam logic [LEN_W-1:0] c_stuck_lim = LEN_W'(STUCK_LIMIT);
    localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);

    logic             w_sampled;
    logic             w_rise;
    logic             w_fall;
    logic             w_edge;
    logic [LEN_W-1:0] w_run_inc;
    logic             w_hit_limit;

    // Length of the current phase in samples, saturating at c_run_max
    logic [LEN_W-1:0] r_run_len;

    jk_edge_detect u_edge (
        .clk     (clk),
        .reset   (reset),
        .q_in    (q_in),
        .sampled (w_sampled),
        .rise    (w_rise),
        .fall    (w_fall)
    );

    assign w_edge      = w_rise | w_fall;
    assign w_run_inc   = (r_run_len == c_run_max) ? r_run_len : (r_run_len + c_run_one);
    // Stuck fires only on the increment that lands on the limit; once the
    // run counter saturates at the same value it must not re-trigger.
    assign w_hit_limit = (w_run_inc == c_stuck_lim) && (r_run_len != c_stuck_lim);

    // Monitor FSM, run-length tracking and registered status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            edge_rise      <= 1'b0;
            edge_fall      <= 1'b0;
            toggle_count   <= '0;
            high_len       <= '0;
            high_len_valid <= 1'b0;
            stuck          <= 1'b0;
            state          <= UNKNOWN;
            r_run_len      <= '0;
        end else begin
            edge_rise      <= 1'b0;
            edge_fall      <= 1'b0;
            high_len_valid <= 1'b0;

            if (!w_sampled) begin
                // First sample after reset: establish the level, no edge
                r_run_len <= c_run_one;
                state     <= jk_level_state(q_in, 1'b0);
            end else if (w_edge) begin
                edge_rise    <= w_rise;
                edge_fall    <= w_fall;
                toggle_count <= toggle_count + c_cnt_one;
                r_run_len    <= c_run_one;
                stuck        <= 1'b0;
                state        <= jk_level_state(w_rise, 1'b0);
                if (w_fall) begin
                    // The phase that just ended was high; report its length
                    high_len       <= r_run_len;
                    high_len_valid <= 1'b1;
                end
            end else begin
                r_run_len <= w_run_inc;
                if (w_hit_limit) begin
                    stuck <= 1'b1;
                    state <= jk_level_state(q_in, 1'b1);
                end
            end

            // Clear overrides the counters and stuck flag but leaves the FSM,
            // so a STUCK state can persist with stuck deasserted until an edge.
            if (clear) begin
                toggle_count   <= '0;
                high_len       <= '0;
                high_len_valid <= 1'b0;
                stuck          <= 1'b0;
            end
        end
    end

endmodule : jk_q_monitor
`default_nettype wire
